// File: rtl/mem_dma_pkg.sv
// State encoding and bus constants shared by the word-granular copy engine.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } dma_state_e;

    localparam logic [3:0]  WSTRB_NONE = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_copy_dma.sv
// Memory-to-memory copy initiator: alternates one read and one write per word
// on the native mem_* bus, then pulses done. Every output comes straight from a flop.
module mem_copy_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    dma_state_e       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] rem_q;
    logic [31:0]      data_q;

    assign mem_instr = 1'b0;
    assign mem_wdata = data_q;

    // Outputs are loaded with the values of the state being entered, so the
    // bus request is already stable in the first cycle of RD/WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= WSTRB_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        rem_q <= len_words;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end else if (len_words == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_addr  <= src_addr;
                            mem_wstrb <= WSTRB_NONE;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        data_q    <= mem_rdata;
                        mem_addr  <= dst_q;
                        mem_wstrb <= WSTRB_WORD;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        src_q     <= src_q + WORD_BYTES;
                        dst_q     <= dst_q + WORD_BYTES;
                        rem_q     <= rem_q - LEN_W'(1);
                        mem_wstrb <= WSTRB_NONE;
                        // rem_q still holds the pre-decrement count here.
                        if (rem_q == LEN_W'(1)) begin
                            mem_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else begin
                            mem_addr <= src_q + WORD_BYTES;
                            state    <= RD;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: memory responder with programmable wait
// states, a copy-order transaction model, and directed latency/boundary vectors.
module tb_mem_copy_dma;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    txn_t        exp_q[$];
    logic [31:0] rd_log[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bit          exp_err = 1'b0;
    bit          mon_en = 1'b0;
    bit          last_hs = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_rst = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic [3:0]  prev_wstrb = '0;
    int          done_total = 0;
    int          txn_count = 0;
    int          valid_cycles = 0;
    int          fixed_delay = 1;
    int          cur_delay = 1;
    int          wait_cnt = 0;
    bit          random_mode = 1'b0;
    bit          idle_noise = 1'b0;

    always #5 clk = ~clk;

    mem_copy_dma #(.LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // The model performs the copy word by word in ascending order on its own
    // memory image, which also fixes the expected result for overlapping regions.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        txn_t        t;
        logic [31:0] ra;
        logic [31:0] wa;
        exp_err = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                ra = s + 32'(4 * i);
                wa = d + 32'(4 * i);
                t.addr  = ra;
                t.wstrb = 4'h0;
                t.wdata = 32'h0;
                exp_q.push_back(t);
                t.addr  = wa;
                t.wstrb = 4'hF;
                t.wdata = ref_rd(ra);
                exp_q.push_back(t);
                ref_mem[wa] = t.wdata;
            end
        end
        @(posedge clk);
        #1;
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= budget && !seen; c++) begin
            @(negedge clk);
            checkOutput("busy_during_job", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            checkOutput("err_at_done", 32'(err), 32'(exp_err));
            @(negedge clk);
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("idle_after_done", 32'(busy), 32'd0);
            checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic check_mem(input string name, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(name, mem_rd(d + 32'(4 * i)), ref_rd(d + 32'(4 * i)));
        end
    endtask

    // Responder: decides mem_ready shortly after each edge; a handshake seen by
    // the monitor at the previous falling edge starts a fresh wait count.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (last_hs) begin
                wait_cnt  = 0;
                cur_delay = random_mode ? int'($urandom_range(0, 5)) : fixed_delay;
            end
            if (mem_valid) begin
                if (wait_cnt >= cur_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = (mem_wstrb == 4'h0) ? mem_rd(mem_addr) : 32'hDEAD_BEEF;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                    mem_rdata = 32'hBAD0_0000 ^ 32'(wait_cnt);
                end
            end else begin
                wait_cnt  = 0;
                mem_ready = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = 32'hBAD1_1111;
            end
        end
    end

    // Monitor: every handshake must be the next transaction of the model.
    initial begin
        forever begin
            @(negedge clk);
            last_hs = mem_valid && mem_ready && !rst;
            if (mon_en) begin
                checkOutput("mem_instr_low", 32'(mem_instr), 32'd0);
                if (prev_stall && !prev_rst) begin
                    checkOutput("valid_held", 32'(mem_valid), 32'd1);
                    if (mem_valid) begin
                        checkOutput("stall_addr", mem_addr, prev_addr);
                        checkOutput("stall_wdata", mem_wdata, prev_wdata);
                        checkOutput("stall_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
                    end
                end
                if (done) done_total++;
                if (mem_valid) valid_cycles++;
                if (last_hs) begin
                    txn_count++;
                    checkOutput("txn_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        txn_t t;
                        t = exp_q.pop_front();
                        checkOutput("txn_addr", mem_addr, t.addr);
                        checkOutput("txn_wstrb", 32'(mem_wstrb), 32'(t.wstrb));
                        if (t.wstrb == 4'hF) checkOutput("txn_wdata", mem_wdata, t.wdata);
                    end
                    if (mem_wstrb == 4'hF) mem[mem_addr] = mem_wdata;
                    else rd_log.push_back(mem_addr);
                end
            end
            prev_stall = mem_valid && !mem_ready;
            prev_rst   = rst;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_wstrb = mem_wstrb;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int v0;
        int d0;
        int t0;
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        preload(32'h100, 32'h1111_1111);
        preload(32'h104, 32'h2222_2222);
        preload(32'h108, 32'h3333_3333);
        preload(32'hFFFF_FFFC, 32'hCAFE_F00D);
        preload(32'h0, 32'h0BAD_C0DE);
        for (int i = 0; i < 8; i++) preload(32'h800 + 32'(4 * i), 32'hA000_0000 + 32'(i * 17));
        for (int i = 0; i < 4; i++) preload(32'h400 + 32'(4 * i), 32'hD000_0000 + 32'(i));

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        $display("[TB] basic copy of 3 words");
        t0 = txn_count;
        d0 = done_total;
        applyStimulus(32'h100, 32'h200, 16'd3);
        wait_done(100, cyc);
        checkOutput("basic_done_cycle", 32'(cyc), 32'd13);
        checkOutput("basic_txn_count", 32'(txn_count - t0), 32'd6);
        checkOutput("basic_done_count", 32'(done_total - d0), 32'd1);
        checkOutput("basic_word0", mem_rd(32'h200), 32'h1111_1111);
        checkOutput("basic_word1", mem_rd(32'h204), 32'h2222_2222);
        checkOutput("basic_word2", mem_rd(32'h208), 32'h3333_3333);
        check_mem("basic_model", 32'h200, 3);

        $display("[TB] zero length with stray ready");
        idle_noise = 1'b1;
        v0 = valid_cycles;
        applyStimulus(32'h100, 32'h200, 16'd0);
        wait_done(10, cyc);
        checkOutput("zero_done_cycle", 32'(cyc), 32'd1);
        checkOutput("zero_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("zero_no_valid", 32'(valid_cycles - v0), 32'd0);
        idle_noise = 1'b0;

        $display("[TB] misaligned source then aligned restart");
        v0 = valid_cycles;
        applyStimulus(32'h102, 32'h200, 16'd3);
        wait_done(10, cyc);
        checkOutput("misalign_done_cycle", 32'(cyc), 32'd1);
        checkOutput("misalign_err", 32'(err), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("misalign_err_sticky", 32'(err), 32'd1);
        checkOutput("misalign_no_valid", 32'(valid_cycles - v0), 32'd0);
        applyStimulus(32'h100, 32'h700, 16'd1);
        wait_done(20, cyc);
        checkOutput("restart_done_cycle", 32'(cyc), 32'd5);
        checkOutput("restart_err_clear", 32'(err), 32'd0);
        checkOutput("restart_word", mem_rd(32'h700), 32'h1111_1111);

        $display("[TB] random wait states, 8 words");
        random_mode = 1'b1;
        d0 = done_total;
        applyStimulus(32'h800, 32'h900, 16'd8);
        wait_done(200, cyc);
        checkOutput("wait_done_count", 32'(done_total - d0), 32'd1);
        check_mem("wait_model", 32'h900, 8);
        checkOutput("wait_word7", mem_rd(32'h91C), 32'hA000_0077);
        random_mode = 1'b0;
        fixed_delay = 1;
        cur_delay   = 1;

        $display("[TB] address wrap with ignored start pulses");
        rd_log.delete();
        applyStimulus(32'hFFFF_FFFC, 32'h300, 16'd2);
        fork
            wait_done(50, cyc);
            begin
                repeat (2) @(posedge clk);
                #1;
                src_addr  = 32'h500;
                dst_addr  = 32'h510;
                len_words = 16'd5;
                start     = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        checkOutput("wrap_done_cycle", 32'(cyc), 32'd9);
        checkOutput("wrap_read_count", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) begin
            checkOutput("wrap_first_read", rd_log[0], 32'hFFFF_FFFC);
            checkOutput("wrap_second_read", rd_log[1], 32'h0000_0000);
        end
        checkOutput("wrap_word0", mem_rd(32'h300), 32'hCAFE_F00D);
        checkOutput("wrap_word1", mem_rd(32'h304), 32'h0BAD_C0DE);
        checkOutput("ignored_start_untouched", mem_rd(32'h510), fill(32'h510));

        $display("[TB] reset during write of word 2");
        d0 = done_total;
        applyStimulus(32'h400, 32'h600, 16'd4);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pre_rst_wstrb", 32'(mem_wstrb), 32'hF);
        checkOutput("pre_rst_addr", mem_addr, 32'h604);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(mem_valid), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("post_rst_no_done", 32'(done_total - d0), 32'd0);
        checkOutput("post_rst_word0", mem_rd(32'h600), 32'hD000_0000);
        checkOutput("post_rst_word1", mem_rd(32'h604), fill(32'h604));
        applyStimulus(32'h400, 32'h600, 16'd4);
        wait_done(100, cyc);
        checkOutput("rerun_done_cycle", 32'(cyc), 32'd17);
        check_mem("rerun_model", 32'h600, 4);
        checkOutput("rerun_word3", mem_rd(32'h60C), 32'hD000_0003);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-granular memory-to-memory copy engine acting as an initiator on the native `mem_*` bus (valid/ready, `mem_wstrb`-qualified writes). Software or a bench loads a source address, a destination address and a word count, then pulses `start`. The block issues alternating read and write transactions until the count is exhausted, then pulses `done`. It sits beside the CPU on the same memory responder and is arbitrated externally; it never drives instruction fetches.

## Interface
- `LEN_W`, default 16, width of the word-count input; maximum copy is 2^LEN_W−1 words.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request; sampled only in IDLE.
- `src_addr` input 32: byte address of the first source word; must be word-aligned.
- `dst_addr` input 32: byte address of the first destination word; must be word-aligned.
- `len_words` input LEN_W: number of 32-bit words to copy.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: alignment error flag; sticky until the next accepted `start`.
- `mem_valid` output 1: transaction request.
- `mem_instr` output 1: tied to 0.
- `mem_ready` input 1: responder completion.
- `mem_addr` output 32: transaction byte address.
- `mem_wdata` output 32: write data.
- `mem_wstrb` output 4: 4'h0 for a read, 4'hF for a write.
- `mem_rdata` input 32: read data, valid in the cycle `mem_valid && mem_ready` is high.

## Operation
- States: IDLE, RD, WR, FIN.
- **IDLE.**
  - On `start`, latch `src_addr`, `dst_addr` and `len_words` into `src_q`, `dst_q` and `rem_q`, and clear `err`.
  - If `src_addr[1:0]` or `dst_addr[1:0]` is nonzero: set `err` and go to FIN with no bus activity.
  - Else if `len_words == 0`: go to FIN.
  - Otherwise go to RD.
- **RD.**
  - Drive `mem_valid=1`, `mem_addr=src_q`, `mem_wstrb=0`.
  - On `mem_ready`: capture `mem_rdata` into `data_q`, then go to WR.
- **WR.**
  - Drive `mem_valid=1`, `mem_addr=dst_q`, `mem_wdata=data_q`, `mem_wstrb=4'hF`.
  - On `mem_ready`: add 4 to `src_q` and `dst_q`, and subtract 1 from `rem_q`.
  - Go to FIN if `rem_q == 1` before the decrement; otherwise go to RD.
- **FIN.** Drive `done=1` for exactly one cycle, then go to IDLE.
- Bus rules:
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable while `mem_valid=1` and `mem_ready=0`.
  - A transaction completes only in a cycle with `mem_valid && mem_ready`.
  - `mem_valid` is never withdrawn before completion.
  - Back-to-back transactions are allowed: the next request is presented in the cycle after completion.
- Pointer arithmetic is unsigned 32-bit and wraps modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
- `start` is ignored while `busy`. An unbounded `mem_ready=0` stalls the block indefinitely; there is no timeout.
- Overlapping source and destination regions are copied in ascending address order; no overlap correction.

## Timing
- All outputs are registered from state and datapath flops; no combinational path from inputs to `mem_*` outputs.
- Reset values:
  - state IDLE; `busy=0`, `done=0`, `err=0`, `mem_valid=0`, `mem_instr=0`, `mem_wstrb=0`.
  - `mem_addr`, `mem_wdata`, `src_q`, `dst_q`, `rem_q`, `data_q` all 0.
- `rst` mid-transfer: at the sampling edge, all outputs take their reset values, including `mem_valid` dropping even if the handshake is incomplete. No `done` is produced for the aborted copy.
- Latency with `start` sampled in cycle 0 and a responder that raises `mem_ready` one cycle after `mem_valid`:
  - First read request in cycle 1.
  - Each word costs 4 cycles.
  - `done` is high in cycle 4N+1.
  - `busy` is high in cycles 1 through 4N+1.
- Zero-length or misaligned request: `done` (and `err`, if misaligned) is high in cycle 1; `mem_valid` never asserts.
- `mem_ready` arriving while `mem_valid=0` is ignored.

## Structure
- Package `mem_dma_pkg` holds:
  - `dma_state_e` (IDLE, RD, WR, FIN);
  - constants `WSTRB_NONE=4'h0`, `WSTRB_WORD=4'hF`, `WORD_BYTES=4`.
- Single module, no sub-modules; the FSM and datapath are small enough to stay flat.

## Test plan
- Basic copy: responder preloaded with words 0x11111111..0x33333333 at 0x100; `start` with src=0x100, dst=0x200, len=3.
  - Expect 6 transactions alternating read and write.
  - Memory at 0x200..0x208 equals the source words.
  - `done` in cycle 13.
- Zero length: len=0 → `done` in cycle 1, `err=0`, `mem_valid` never high.
- Misaligned: src=0x102 → `err=1` and `done` in cycle 1, no bus activity; a following aligned `start` clears `err`.
- Wait states: responder delays `mem_ready` 0–5 random cycles, len=8.
  - Address, data and strobe stay stable while stalled.
  - Copy is correct; `done` fires exactly once.
- Wrap and ignore: src=0xFFFFFFFC, len=2 → second read address is 0x00000000; `start` pulses while busy do not disturb the transfer.
- Reset mid-copy: assert `rst` during WR of word 2 of len=4.
  - `mem_valid=0` and `busy=0` the next cycle; no `done`.
  - A fresh `start` then completes normally.
